// File: rtl/hilo_div_pkg.sv
// Shared definitions for the Hi/Lo multi-cycle divider: FSM states, widths and
// the divide-by-zero quotient value.
package hilo_div_pkg;

  localparam int unsigned WIDTH      = 32;
  localparam int unsigned DIV_CYCLES = 32;

  localparam logic [WIDTH-1:0] DIV_ZERO_QUOT = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    StIdle,
    StCalc,
    StFix,
    StDone
  } divState_e;

endpackage

// File: rtl/div_step.sv
// One restoring shift-subtract step: brings in the next dividend bit, trial-subtracts
// the divisor and returns the new partial remainder plus the resolved quotient bit.
module div_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] remIn,
  input  logic             dividendBit,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] remOut,
  output logic             quotBit
);

  logic [WIDTH:0] partial;
  logic [WIDTH:0] diff;
  logic           unusedDiffTop;

  // remIn < divisor always holds, so the kept or reduced remainder fits in WIDTH bits.
  always_comb begin
    partial = {remIn, dividendBit};
    diff    = partial - {1'b0, divisor};
    quotBit = (partial >= {1'b0, divisor});
    remOut  = quotBit ? diff[WIDTH-1:0] : partial[WIDTH-1:0];
  end

  assign unusedDiffTop = diff[WIDTH];

endmodule

// File: rtl/hilo_divider.sv
// Multi-cycle div/divu unit for the execute stage: quotient to Lo, remainder to Hi,
// Busy while working so the hazard unit can stall Hi/Lo consumers.
module hilo_divider #(
  parameter int unsigned WIDTH = hilo_div_pkg::WIDTH
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic             Signed,
  input  logic [WIDTH-1:0] Dividend,
  input  logic [WIDTH-1:0] Divisor,
  input  logic             Flush,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Quotient,
  output logic [WIDTH-1:0] Remainder,
  output logic             DivByZero
);

  import hilo_div_pkg::*;

  localparam int unsigned CntW = $clog2(WIDTH);

  divState_e       stateQ, stateD;
  logic [CntW-1:0] countQ, countD;
  logic [WIDTH-1:0] remQ, remD;
  logic [WIDTH-1:0] qQ, qD;
  logic [WIDTH-1:0] divisorQ, divisorD;
  logic            qSignQ, qSignD;
  logic            rSignQ, rSignD;
  logic [WIDTH-1:0] quotQ, quotD;
  logic [WIDTH-1:0] remOutQ, remOutD;
  logic            dbzQ, dbzD;
  logic [WIDTH-1:0] stepRem;
  logic            stepBit;
  logic            accept;

  div_step #(
    .WIDTH(WIDTH)
  ) uStep (
    .remIn      (remQ),
    .dividendBit(qQ[WIDTH-1]),
    .divisor    (divisorQ),
    .remOut     (stepRem),
    .quotBit    (stepBit)
  );

  assign accept = Start && !Flush && (stateQ == StIdle || stateQ == StDone);

  always_comb begin
    stateD   = stateQ;
    countD   = countQ;
    remD     = remQ;
    qD       = qQ;
    divisorD = divisorQ;
    qSignD   = qSignQ;
    rSignD   = rSignQ;
    quotD    = quotQ;
    remOutD  = remOutQ;
    dbzD     = dbzQ;

    if (Flush) begin
      stateD = StIdle;
    end else begin
      unique case (stateQ)
        StCalc: begin
          remD = stepRem;
          qD   = {qQ[WIDTH-2:0], stepBit};
          if (countQ == '0) begin
            stateD = StFix;
          end else begin
            countD = countQ - 1'b1;
          end
        end
        StFix: begin
          quotD   = qSignQ ? -qQ : qQ;
          remOutD = rSignQ ? -remQ : remQ;
          dbzD    = 1'b0;
          stateD  = StDone;
        end
        StDone:  stateD = StIdle;
        default: stateD = StIdle;
      endcase

      // Divide by zero skips CALC and publishes its fixed result on the entry edge.
      if (accept) begin
        if (Divisor == '0) begin
          quotD   = WIDTH'(DIV_ZERO_QUOT);
          remOutD = Dividend;
          dbzD    = 1'b1;
          stateD  = StDone;
        end else begin
          qD       = (Signed && Dividend[WIDTH-1]) ? -Dividend : Dividend;
          divisorD = (Signed && Divisor[WIDTH-1]) ? -Divisor : Divisor;
          qSignD   = Signed && (Dividend[WIDTH-1] ^ Divisor[WIDTH-1]);
          rSignD   = Signed && Dividend[WIDTH-1];
          remD     = '0;
          countD   = CntW'(WIDTH - 1);
          stateD   = StCalc;
        end
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      stateQ   <= StIdle;
      countQ   <= '0;
      remQ     <= '0;
      qQ       <= '0;
      divisorQ <= '0;
      qSignQ   <= 1'b0;
      rSignQ   <= 1'b0;
      quotQ    <= '0;
      remOutQ  <= '0;
      dbzQ     <= 1'b0;
    end else begin
      stateQ   <= stateD;
      countQ   <= countD;
      remQ     <= remD;
      qQ       <= qD;
      divisorQ <= divisorD;
      qSignQ   <= qSignD;
      rSignQ   <= rSignD;
      quotQ    <= quotD;
      remOutQ  <= remOutD;
      dbzQ     <= dbzD;
    end
  end

  assign Busy      = (stateQ == StCalc) || (stateQ == StFix);
  assign Done      = (stateQ == StDone);
  assign Quotient  = quotQ;
  assign Remainder = remOutQ;
  assign DivByZero = dbzQ;

endmodule

// File: tb/tb_hilo_divider.sv
// Randomized and directed bench for hilo_divider against a plain-arithmetic
// reference model of div/divu, including latency, flush and reset behaviour.
module tb_hilo_divider;

  logic        Clk;
  logic        Reset;
  logic        Start;
  logic        Signed;
  logic [31:0] Dividend;
  logic [31:0] Divisor;
  logic        Flush;
  logic        Busy;
  logic        Done;
  logic [31:0] Quotient;
  logic [31:0] Remainder;
  logic        DivByZero;

  int nChecks = 0;
  int nFails  = 0;

  logic [31:0] lastQ = '0;
  logic [31:0] lastR = '0;
  logic        lastZ = 1'b0;

  hilo_divider #(
    .WIDTH(32)
  ) dut (
    .Clk      (Clk),
    .Reset    (Reset),
    .Start    (Start),
    .Signed   (Signed),
    .Dividend (Dividend),
    .Divisor  (Divisor),
    .Flush    (Flush),
    .Busy     (Busy),
    .Done     (Done),
    .Quotient (Quotient),
    .Remainder(Remainder),
    .DivByZero(DivByZero)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got !== exp) begin
      nFails++;
      $display("FAIL %s: got 0x%h, expected 0x%h", tag, got, exp);
    end
  endtask

  // MIPS semantics: truncating division, remainder takes the dividend's sign.
  function automatic void refDiv(input bit sgn, input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] q, output logic [31:0] r,
                                 output logic z);
    longint sa, sb;
    if (b == 0) begin
      q = 32'hFFFF_FFFF;
      r = a;
      z = 1'b1;
    end else if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q  = 32'(sa / sb);
      r  = 32'(sa % sb);
      z  = 1'b0;
    end else begin
      q = a / b;
      r = a % b;
      z = 1'b0;
    end
  endfunction

  // Called at a negedge; returns at the negedge where Done is first seen.
  task automatic runDiv(input bit sgn, input logic [31:0] a, input logic [31:0] b,
                        input string tag);
    logic [31:0] eq, er;
    logic        ez;
    int          lat = 0;
    int          busyCnt = 0;
    bit          got = 0;
    Start    = 1'b1;
    Signed   = sgn;
    Dividend = a;
    Divisor  = b;
    for (int c = 1; c <= 60 && !got; c++) begin
      @(negedge Clk);
      if (c == 1) Start = 1'b0;
      if (Done) begin
        got = 1;
        lat = c;
        checkEq({tag, " busy-with-done"}, 32'(Busy), 32'd0);
      end else begin
        if (Busy) busyCnt++;
        if (c == 17) begin
          checkEq({tag, " q-stable"}, Quotient, lastQ);
          checkEq({tag, " r-stable"}, Remainder, lastR);
        end
      end
    end
    refDiv(sgn, a, b, eq, er, ez);
    checkEq({tag, " latency"}, 32'(lat), (b == 0) ? 32'd1 : 32'd34);
    checkEq({tag, " busy-cycles"}, 32'(busyCnt), (b == 0) ? 32'd0 : 32'd33);
    checkEq({tag, " quotient"}, Quotient, eq);
    checkEq({tag, " remainder"}, Remainder, er);
    checkEq({tag, " divbyzero"}, 32'(DivByZero), 32'(ez));
    lastQ = eq;
    lastR = er;
    lastZ = ez;
  endtask

  task automatic finishDiv(input string tag);
    @(negedge Clk);
    checkEq({tag, " done-pulse"}, 32'(Done), 32'd0);
    checkEq({tag, " q-hold"}, Quotient, lastQ);
  endtask

  task automatic expectNoDone(input string tag);
    bit seen = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge Clk);
      if (Done) seen = 1;
    end
    checkEq({tag, " no-done"}, 32'(seen), 32'd0);
    checkEq({tag, " q-kept"}, Quotient, lastQ);
    checkEq({tag, " r-kept"}, Remainder, lastR);
    checkEq({tag, " z-kept"}, 32'(DivByZero), 32'(lastZ));
  endtask

  initial begin
    logic [31:0] a, b;
    bit          sgn;

    Reset    = 1'b0;
    Start    = 1'b0;
    Signed   = 1'b0;
    Dividend = '0;
    Divisor  = '0;
    Flush    = 1'b0;
    #3;
    checkEq("reset quotient", Quotient, 32'd0);
    checkEq("reset remainder", Remainder, 32'd0);
    checkEq("reset divbyzero", 32'(DivByZero), 32'd0);
    checkEq("reset busy", 32'(Busy), 32'd0);
    checkEq("reset done", 32'(Done), 32'd0);
    @(negedge Clk);
    Reset = 1'b1;
    @(negedge Clk);

    runDiv(1'b0, 32'd100, 32'd7, "divu 100/7");
    finishDiv("divu 100/7");
    runDiv(1'b1, -32'sd7, 32'd2, "div -7/2");
    finishDiv("div -7/2");
    runDiv(1'b1, 32'd7, -32'sd2, "div 7/-2");
    finishDiv("div 7/-2");
    runDiv(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, "div ovf");
    finishDiv("div ovf");
    runDiv(1'b0, 32'hFFFF_FFFF, 32'd1, "divu max/1");
    finishDiv("divu max/1");
    runDiv(1'b1, 32'h0000_1234, 32'd0, "div by zero");
    finishDiv("div by zero");

    for (int i = 0; i < 16; i++) begin
      sgn = 1'($urandom_range(0, 1));
      a   = $urandom;
      case ($urandom_range(0, 3))
        0:       b = $urandom_range(1, 15);
        1:       b = $urandom;
        2:       b = -$urandom_range(1, 15);
        default: b = (i % 5 == 0) ? 32'd0 : $urandom;
      endcase
      runDiv(sgn, a, b, $sformatf("rand%0d", i));
      finishDiv($sformatf("rand%0d", i));
    end

    runDiv(1'b0, 32'd500, 32'd9, "pre-flush");
    finishDiv("pre-flush");
    Start    = 1'b1;
    Signed   = 1'b0;
    Dividend = 32'd1000;
    Divisor  = 32'd3;
    for (int c = 1; c <= 10; c++) begin
      @(negedge Clk);
      if (c == 1) Start = 1'b0;
    end
    Flush = 1'b1;
    @(negedge Clk);
    Flush = 1'b0;
    checkEq("flush busy", 32'(Busy), 32'd0);
    expectNoDone("flush");

    Start    = 1'b1;
    Flush    = 1'b1;
    Dividend = 32'd77;
    Divisor  = 32'd5;
    @(negedge Clk);
    Start = 1'b0;
    Flush = 1'b0;
    checkEq("start+flush busy", 32'(Busy), 32'd0);
    expectNoDone("start+flush");

    // Second Start is driven in the DONE cycle of the first.
    runDiv(1'b0, 32'd12345, 32'd10, "b2b first");
    runDiv(1'b0, 32'd1000, 32'd7, "b2b second");
    finishDiv("b2b second");

    Start    = 1'b1;
    Signed   = 1'b1;
    Dividend = 32'd999;
    Divisor  = 32'd4;
    for (int c = 1; c <= 20; c++) begin
      @(negedge Clk);
      if (c == 1) Start = 1'b0;
    end
    #2 Reset = 1'b0;
    #1;
    checkEq("async reset quotient", Quotient, 32'd0);
    checkEq("async reset remainder", Remainder, 32'd0);
    checkEq("async reset divbyzero", 32'(DivByZero), 32'd0);
    checkEq("async reset busy", 32'(Busy), 32'd0);
    checkEq("async reset done", 32'(Done), 32'd0);
    @(negedge Clk);
    Reset = 1'b1;
    lastQ = '0;
    lastR = '0;
    lastZ = 1'b0;
    expectNoDone("after reset");

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
